// File: rtl/mt_fetch_sequencer.sv
// mt_fetch_sequencer: per-thread PCs, round-robin grant, registered fetch address
module mt_fetch_sequencer #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int NUM_THREADS = 4,
  parameter int ALIGN_BITS = 2,
  parameter int RESET_PC = 0,
  parameter int THREAD_STRIDE = 0,
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int AW = ADDRESS_WIDTH
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset_n,
  input  logic                        i_Stall,
  input  logic [NUM_THREADS-1:0]      i_thread_enable,
  input  logic                        i_pred_taken,
  input  logic [AW-1:0]               i_pred_target,
  input  logic [NUM_THREADS-1:0]      i_redirect,
  input  logic [NUM_THREADS*AW-1:0]   i_redirect_target,
  output logic [AW-1:0]               o_PC,
  output logic [TID_W-1:0]            o_thread_id,
  output logic                        o_fetch_valid
);
  logic [AW-1:0] pc_q [NUM_THREADS];
  logic [AW-1:0] pc_d [NUM_THREADS];
  logic [AW-1:0] eff [NUM_THREADS];
  logic [AW-1:0] pc_o_q;
  logic [TID_W-1:0] rr_q, tid_q, sel, cand;
  logic valid_q, found, grant, pred_ok;

  function automatic logic [AW-1:0] seq(input logic [AW-1:0] a);
    return AW'(((a >> ALIGN_BITS) + AW'(1)) << ALIGN_BITS);
  endfunction

  // search rr_q+N down to rr_q+1 so the nearest successor of rr_q wins
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand = TID_W'((int'(rr_q) + k) % NUM_THREADS);
      if (i_thread_enable[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = found & ~i_Stall;
  assign pred_ok = i_pred_taken & valid_q & ~i_Stall;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      eff[t] = i_redirect[t] ? i_redirect_target[t*AW +: AW]
             : (pred_ok && tid_q == TID_W'(t)) ? i_pred_target : pc_q[t];
      pc_d[t] = (grant && sel == TID_W'(t)) ? seq(eff[t]) : eff[t];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= AW'(RESET_PC + t * THREAD_STRIDE);
      rr_q <= TID_W'(NUM_THREADS - 1);
      pc_o_q <= '0;
      tid_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (!i_Stall) begin
        valid_q <= found;
        if (found) begin
          pc_o_q <= eff[sel];
          tid_q <= sel;
          rr_q <= sel;
        end
      end
    end
  end

  assign o_PC = pc_o_q;
  assign o_thread_id = tid_q;
  assign o_fetch_valid = valid_q;
endmodule

// File: tb/tb_mt_fetch_sequencer.sv
// tb_mt_fetch_sequencer: directed plus random checks against a thread-level reference model
module tb_mt_fetch_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, stall, pred;
  logic [3:0] en, redir;
  logic [21:0] ptgt;
  logic [21:0] rt [4];
  logic [87:0] rt_flat;
  logic [21:0] o_pc;
  logic [1:0] o_tid;
  logic o_v;
  assign rt_flat = {rt[3], rt[2], rt[1], rt[0]};

  logic c1_rst_n, c1_en, c1_pred;
  logic [21:0] c1_ptgt;
  logic [21:0] c1_pc;
  logic c1_tid, c1_v;

  mt_fetch_sequencer #(.ADDRESS_WIDTH(22), .NUM_THREADS(4), .ALIGN_BITS(2),
    .RESET_PC(32'h100), .THREAD_STRIDE(32'h40)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall), .i_thread_enable(en),
    .i_pred_taken(pred), .i_pred_target(ptgt), .i_redirect(redir),
    .i_redirect_target(rt_flat), .o_PC(o_pc), .o_thread_id(o_tid), .o_fetch_valid(o_v));

  mt_fetch_sequencer #(.ADDRESS_WIDTH(22), .NUM_THREADS(1), .ALIGN_BITS(2),
    .RESET_PC(32'h20), .THREAD_STRIDE(0)) dut1 (
    .i_Clk(clk), .i_Reset_n(c1_rst_n), .i_Stall(1'b0), .i_thread_enable(c1_en),
    .i_pred_taken(c1_pred), .i_pred_target(c1_ptgt), .i_redirect(1'b0),
    .i_redirect_target(22'h0), .o_PC(c1_pc), .o_thread_id(c1_tid), .o_fetch_valid(c1_v));

  int checks = 0, errors = 0;
  int m_pc [4];
  int m_o, m_tid, m_v, m_rr;
  logic [21:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int a);
    return (((a / 4) + 1) * 4) % (1 << 22);
  endfunction

  // reference: each cycle resolve every thread's address, then pick the next enabled thread after the last grant
  task automatic model();
    int e [4];
    int g;
    if (!rst_n) begin
      m_o = 0; m_tid = 0; m_v = 0; m_rr = 3;
      for (int t = 0; t < 4; t++) m_pc[t] = 'h100 + t * 'h40;
      return;
    end
    for (int t = 0; t < 4; t++)
      e[t] = redir[t] ? int'(rt[t]) : (pred && m_v == 1 && !stall && m_tid == t) ? int'(ptgt) : m_pc[t];
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && en[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    for (int t = 0; t < 4; t++) m_pc[t] = e[t];
    if (!stall) begin
      m_v = (g >= 0) ? 1 : 0;
      if (g >= 0) begin
        m_o = e[g]; m_tid = g; m_rr = g; m_pc[g] = nxt(e[g]);
      end
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("valid", {31'b0, o_v}, m_v);
    chk("pc", {10'b0, o_pc}, m_o);
    chk("tid", {30'b0, o_tid}, m_tid);
  endtask

  initial begin
    rst_n = 0; stall = 0; pred = 0; en = 4'hF; redir = 0; ptgt = 0;
    for (int t = 0; t < 4; t++) rt[t] = 0;
    c1_rst_n = 0; c1_en = 0; c1_pred = 0; c1_ptgt = 0;
    step();
    step();
    chk("rst_valid", {31'b0, o_v}, 0);
    chk("rst_pc", {10'b0, o_pc}, 0);
    c1_rst_n = 1; c1_en = 1;
    step();
    chk("n1_first", {10'b0, c1_pc}, 'h20);
    chk("n1_valid", {31'b0, c1_v}, 1);
    c1_pred = 1; c1_ptgt = 22'h300;
    step();
    chk("n1_pred", {10'b0, c1_pc}, 'h300);
    c1_pred = 0;
    step();
    chk("n1_seq", {10'b0, c1_pc}, 'h304);
    rst_n = 1;
    step(); chk("seq0", {10'b0, o_pc}, 'h100);
    step(); chk("seq1", {10'b0, o_pc}, 'h140);
    step(); chk("seq2", {10'b0, o_pc}, 'h180);
    step(); chk("seq3", {10'b0, o_pc}, 'h1C0);
    step(); chk("seq4", {10'b0, o_pc}, 'h104);
    en = 4'b1010;
    step(); chk("alt_t1", {30'b0, o_tid}, 1);
    step(); chk("alt_t3", {30'b0, o_tid}, 3);
    en = 4'b1011;
    step(); chk("join_t0", {10'b0, o_pc}, 'h108);
    step(); chk("join_t1", {10'b0, o_pc}, 'h148);
    en = 4'b0000;
    step(); chk("none_v", {31'b0, o_v}, 0); chk("none_pc", {10'b0, o_pc}, 'h148);
    en = 4'hF;
    step(); chk("t2_pick", {30'b0, o_tid}, 2);
    redir = 4'b0100; rt[2] = 22'h77; pred = 1; ptgt = 22'h999; en = 4'b0100;
    step(); chk("redir_win", {10'b0, o_pc}, 'h77);
    redir = 0; pred = 0;
    step(); chk("redir_succ", {10'b0, o_pc}, 'h78);
    held = o_pc; en = 4'hF; stall = 1;
    step(); chk("stall1", {10'b0, o_pc}, {10'b0, held});
    redir = 4'b0100; rt[2] = 22'h500;
    step(); chk("stall2", {10'b0, o_pc}, {10'b0, held});
    redir = 0;
    step(); chk("stall3", {10'b0, o_pc}, {10'b0, held});
    stall = 0;
    step(); chk("rr_frozen", {30'b0, o_tid}, 3);
    en = 4'b0100;
    step(); chk("stall_redir", {10'b0, o_pc}, 'h500);
    redir = 4'b0010; rt[1] = 22'h3FFFFC; en = 4'b0010;
    step(); chk("wrap_top", {10'b0, o_pc}, 'h3FFFFC);
    redir = 0;
    step(); chk("wrap_zero", {10'b0, o_pc}, 0);
    for (int i = 0; i < 400; i++) begin
      en = 4'($urandom);
      stall = ($urandom_range(0, 5) == 0);
      pred = 1'($urandom);
      ptgt = 22'($urandom);
      for (int t = 0; t < 4; t++) begin
        redir[t] = ($urandom_range(0, 7) == 0);
        rt[t] = 22'($urandom);
      end
      step();
    end
    stall = 1; redir = 4'hF; pred = 1; rst_n = 0;
    step(); chk("mid_rst_v", {31'b0, o_v}, 0); chk("mid_rst_pc", {10'b0, o_pc}, 0);
    stall = 0; redir = 0; pred = 0; rst_n = 1; en = 4'hF;
    step(); chk("post_rst_t0", {10'b0, o_pc}, 'h100);
    step(); chk("post_rst_t1", {10'b0, o_pc}, 'h140);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mt_fetch_sequencer.md
# mt_fetch_sequencer

Parametrised multithreaded fetch-address sequencer for the front end. It holds one PC per hardware thread and picks one enabled thread per cycle by round-robin. The chosen thread's fetch address goes to the instruction cache, registered. Each thread's PC advances sequentially, by predicted-taken target, or by EX redirect, with same-cycle bypass so the issued address is never stale.

## Interface
- ADDRESS_WIDTH, 22, width of every PC and target
- NUM_THREADS, 4, hardware thread count (≥1); TID_W = max(1, clog2(NUM_THREADS))
- ALIGN_BITS, 2, log2 of fetch-block size in address units; sequential step goes to the next aligned block
- RESET_PC, 0, reset PC of thread 0
- THREAD_STRIDE, 0, reset PC of thread t = RESET_PC + t*THREAD_STRIDE (mod 2^ADDRESS_WIDTH)

- i_Clk  in  1  single clock, all state on rising edge
- i_Reset_n  in  1  reset, synchronous, active-low
- i_Stall  in  1  freeze issue: outputs, round-robin pointer and prediction updates hold
- i_thread_enable  in  NUM_THREADS  thread t may be granted when bit t = 1
- i_pred_taken  in  1  predictor: the address on o_PC / o_thread_id is a taken branch
- i_pred_target  in  ADDRESS_WIDTH  predicted target for that thread
- i_redirect  in  NUM_THREADS  EX mispredict or jr: bit t redirects thread t
- i_redirect_target  in  NUM_THREADS*ADDRESS_WIDTH  flat; slice t = [(t+1)*ADDRESS_WIDTH-1 : t*ADDRESS_WIDTH]
- o_PC  out  ADDRESS_WIDTH  registered fetch address
- o_thread_id  out  TID_W  registered thread owning o_PC
- o_fetch_valid  out  1  o_PC / o_thread_id are a real fetch

## Operation
- State: pc[t] per thread, meaning the next address to issue for thread t. rr_ptr (TID_W) holds the last granted thread.
- Sequential step: seq(a) = {a[AW-1:ALIGN_BITS]+1, ALIGN_BITS'b0}, truncated to ADDRESS_WIDTH. This wraps 2^AW-1 → 0. Unaligned targets are issued unaligned; their successor is the next aligned block.
- Grant, when not stalled: sel = first t with i_thread_enable[t]=1, searching rr_ptr+1, rr_ptr+2, … mod NUM_THREADS (rr_ptr itself is searched last).
  - If none is enabled: o_fetch_valid<=0, o_PC / o_thread_id hold, rr_ptr holds.
- Per-thread next-address source, priority highest first:
  1. i_redirect[t] → i_redirect_target[t]. Accepted even when i_Stall=1 or the thread is disabled.
  2. Prediction: i_pred_taken & o_fetch_valid & !i_Stall, for t == o_thread_id → i_pred_target. Ignored if 1 applies to that thread.
  3. Otherwise pc[t].
  - Call the result eff[t].
- On a grant: o_PC<=eff[sel], o_thread_id<=sel, o_fetch_valid<=1, rr_ptr<=sel, pc[sel]<=seq(eff[sel]).
- Non-granted threads: pc[t]<=eff[t].
- During stall: only redirects write pc[]. A held o_PC may be wrong-path; downstream squashes it.

## Timing
- Reset (i_Reset_n=0 at an edge): o_PC=0, o_thread_id=0, o_fetch_valid=0, rr_ptr=NUM_THREADS-1, pc[t]=RESET_PC+t*THREAD_STRIDE. Reset wins over stall and redirect. The first grant after release goes to thread 0 if enabled.
- Latency: one cycle from grant decision to o_PC.
  - A redirect in cycle n to a thread granted in n is issued at n+1 (bypass). Otherwise it is issued at that thread's next grant.
  - The prediction for the o_PC shown in cycle n takes effect at n+1 if the same thread is granted, else at its next grant.
- A redirect and a prediction on the same thread in the same cycle: the redirect wins.
- NUM_THREADS=1: the grant is always thread 0 when enabled, giving back-to-back issue with prediction bypass every cycle.
- Enable changes take effect in the same cycle's grant. Disabling a thread never alters its pc[].

## Test plan
- Reset with RESET_PC=0x100, THREAD_STRIDE=0x40, all enabled, no stall → o_PC sequence 0x100(t0), 0x140(t1), 0x180(t2), 0x1C0(t3), 0x104(t0), …; o_fetch_valid=0 during reset.
- i_thread_enable=4'b1010 → grants alternate t1, t3; enable t0 mid-run → it joins at its next rotation slot; enable=0 → o_fetch_valid=0 and o_PC holds.
- NUM_THREADS=1: o_PC=0x20 with i_pred_taken=1, i_pred_target=0x300 → next o_PC=0x300, then 0x304.
- Same cycle: i_redirect[o_thread_id]=1 with target 0x77 and i_pred_taken=1 → that thread's next issue is 0x77, then 0x78 (aligned successor).
- i_Stall=1 for 3 cycles with i_redirect[2] (target 0x500) in the middle → o_PC / rr_ptr frozen; after release, thread 2's next issue is 0x500.
- pc = 2^22-4 → seq issues 0x0; reset asserted mid-run during a stall → every register returns to its reset value on the next edge.
